// File: rtl/http_flood_detector.sv
// Per-source HTTP GET/POST rate detector: drops headers whose source IP exceeds threshold per window.
// Latency: verdict 3 cycles after accept; one header in flight at a time.
// Backpressure: o_hdr_rdy drops for the two cycles after an accept; max one header every 3 cycles.
//
// Ports:
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_hdr_valid / o_hdr_rdy    header handshake; i_src_ip, i_dst_port, i_proto, i_http_get, i_http_post
//   i_enable, i_threshold      software controls, sampled in the update cycle
//   o_verdict_*                one-cycle verdict pulse with drop flag and source IP
//   o_flood_drop_count         saturating count of drop verdicts (kept across windows)
//   o_entries_used             number of valid table entries
module http_flood_detector #(
  parameter int NUM_ENTRIES   = 8,
  parameter int CNT_WIDTH     = 16,
  parameter int WINDOW_CYCLES = 125000000,
  parameter int HTTP_PORT     = 80
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_hdr_valid,
  output logic                         o_hdr_rdy,
  input  logic [31:0]                  i_src_ip,
  input  logic [15:0]                  i_dst_port,
  input  logic [7:0]                   i_proto,
  input  logic                         i_http_get,
  input  logic                         i_http_post,
  input  logic                         i_enable,
  input  logic [CNT_WIDTH-1:0]         i_threshold,
  output logic                         o_verdict_valid,
  output logic                         o_verdict_drop,
  output logic [31:0]                  o_verdict_src_ip,
  output logic [31:0]                  o_flood_drop_count,
  output logic [$clog2(NUM_ENTRIES):0] o_entries_used
);

  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int TW = $clog2(WINDOW_CYCLES);

  typedef enum logic [1:0] {IDLE, CMP, UPD} state_t;

  state_t                r_state, w_next;
  logic [31:0]           r_ip;
  logic                  r_cand;
  logic                  r_valid [NUM_ENTRIES];
  logic [31:0]           r_tab_ip[NUM_ENTRIES];
  logic [CNT_WIDTH-1:0]  r_cnt   [NUM_ENTRIES];
  logic                  r_hit, r_full, r_stale;
  logic [IW-1:0]         r_hit_idx, r_free_idx, r_vptr;
  logic [TW-1:0]         r_timer;

  logic                  w_tick, w_accept, w_hit, w_full, w_drop;
  logic [IW-1:0]         w_hit_idx, w_free_idx, w_tgt;
  logic [CNT_WIDTH-1:0]  w_new_cnt;
  logic [IW:0]           w_used;

  assign w_tick   = (r_timer == TW'(WINDOW_CYCLES - 1));
  assign w_accept = i_hdr_valid && o_hdr_rdy;

  // FSM next state and handshake output
  always_comb begin
    w_next    = r_state;
    o_hdr_rdy = 1'b0;
    case (r_state)
      IDLE: begin
        o_hdr_rdy = 1'b1;
        if (i_hdr_valid) w_next = CMP;
      end
      CMP:     w_next = UPD;
      UPD:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Parallel compare; descending scan so the lowest matching/free index wins
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free_idx = '0;
    w_full     = 1'b1;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tab_ip[i] == r_ip)) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
      if (!r_valid[i]) begin
        w_full     = 1'b0;
        w_free_idx = IW'(i);
      end
    end
  end

  // Target slot and new count. A tick during CMP invalidates the compare
  // results, so the packet goes to slot 0 of what is now an empty table.
  always_comb begin
    w_tgt     = r_vptr;
    w_new_cnt = CNT_WIDTH'(1);
    if (r_stale) begin
      w_tgt = '0;
    end else if (r_hit) begin
      w_tgt     = r_hit_idx;
      w_new_cnt = (r_cnt[r_hit_idx] == '1) ? r_cnt[r_hit_idx]
                                           : r_cnt[r_hit_idx] + CNT_WIDTH'(1);
    end else if (!r_full) begin
      w_tgt = r_free_idx;
    end
    // Tick coinciding with the update: table clears, packet counts as first
    if (w_tick) w_new_cnt = CNT_WIDTH'(1);
    w_drop = r_cand && i_enable && (w_new_cnt > i_threshold);
  end

  always_comb begin
    w_used = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) w_used = w_used + (IW+1)'(r_valid[i]);
  end
  assign o_entries_used = w_used;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ip               <= '0;
      r_cand             <= 1'b0;
      r_hit              <= 1'b0;
      r_full             <= 1'b0;
      r_stale            <= 1'b0;
      r_hit_idx          <= '0;
      r_free_idx         <= '0;
      r_vptr             <= '0;
      r_timer            <= '0;
      o_verdict_valid    <= 1'b0;
      o_verdict_drop     <= 1'b0;
      o_verdict_src_ip   <= '0;
      o_flood_drop_count <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tab_ip[i] <= '0;
        r_cnt[i]    <= '0;
      end
    end else begin
      r_timer <= w_tick ? '0 : r_timer + TW'(1);

      if (w_accept) begin
        r_ip   <= i_src_ip;
        r_cand <= (i_proto == 8'd6) && (i_dst_port == 16'(HTTP_PORT))
                  && (i_http_get || i_http_post);
      end

      if (r_state == CMP) begin
        r_hit      <= w_hit;
        r_hit_idx  <= w_hit_idx;
        r_free_idx <= w_free_idx;
        r_full     <= w_full;
        r_stale    <= w_tick;
      end

      if (w_tick) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          r_valid[i] <= 1'b0;
          r_cnt[i]   <= '0;
        end
      end

      // Install after the clear so a same-cycle tick leaves only this entry
      if (r_state == UPD && r_cand) begin
        r_valid[w_tgt]  <= 1'b1;
        r_tab_ip[w_tgt] <= r_ip;
        r_cnt[w_tgt]    <= w_new_cnt;
        if (!r_stale && !r_hit && r_full) r_vptr <= r_vptr + IW'(1);
      end

      o_verdict_valid <= (r_state == UPD);
      o_verdict_drop  <= (r_state == UPD) && w_drop;
      if (r_state == UPD) o_verdict_src_ip <= r_ip;
      if (r_state == UPD && w_drop && o_flood_drop_count != 32'hFFFF_FFFF)
        o_flood_drop_count <= o_flood_drop_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_http_flood_detector.sv
module tb_http_flood_detector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hdr_valid, hdr_rdy;
  logic [31:0] src_ip;
  logic [15:0] dst_port;
  logic [7:0]  proto;
  logic        http_get, http_post, enable;
  logic [15:0] threshold;
  logic        verdict_valid, verdict_drop;
  logic [31:0] verdict_src_ip, flood_drop_count;
  logic [3:0]  entries_used;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int vcount = 0;
  int exp_v = 0;

  http_flood_detector #(
    .NUM_ENTRIES(8), .CNT_WIDTH(16), .WINDOW_CYCLES(64), .HTTP_PORT(80)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hdr_valid(hdr_valid), .o_hdr_rdy(hdr_rdy),
    .i_src_ip(src_ip), .i_dst_port(dst_port), .i_proto(proto),
    .i_http_get(http_get), .i_http_post(http_post), .i_enable(enable),
    .i_threshold(threshold), .o_verdict_valid(verdict_valid),
    .o_verdict_drop(verdict_drop), .o_verdict_src_ip(verdict_src_ip),
    .o_flood_drop_count(flood_drop_count), .o_entries_used(entries_used)
  );

  always #5 clk = ~clk;

  // Posedges since reset release; after edge k the window timer holds k mod 64
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc = 0;
    else        cyc = cyc + 1;

  always @(negedge clk) if (verdict_valid) vcount = vcount + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rdy"},   32'(hdr_rdy), 32'd1);
    check_eq({tag, "_vv"},    32'(verdict_valid), 32'd0);
    check_eq({tag, "_vd"},    32'(verdict_drop), 32'd0);
    check_eq({tag, "_vip"},   verdict_src_ip, 32'd0);
    check_eq({tag, "_cnt"},   flood_drop_count, 32'd0);
    check_eq({tag, "_used"},  32'(entries_used), 32'd0);
  endtask

  // Returns at a negedge with cyc==0: a header driven now is accepted at edge 1
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    hdr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Called at a negedge with DUT idle; returns at the negedge of the verdict cycle
  task automatic send(input logic [31:0] ip, input logic [15:0] port, input logic [7:0] pr,
                      input logic g, input logic p, input logic exp_drop, input string tag);
    int  lat;
    bit  seen;
    hdr_valid = 1'b1; src_ip = ip; dst_port = port; proto = pr;
    http_get = g; http_post = p;
    @(posedge clk);
    @(negedge clk);
    hdr_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 8) begin
      if (verdict_valid) seen = 1'b1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    exp_v++;
    check_eq({tag, "_lat"},  32'(lat), 32'd3);
    check_eq({tag, "_drop"}, 32'(verdict_drop), 32'(exp_drop));
    check_eq({tag, "_ip"},   verdict_src_ip, ip);
  endtask

  localparam logic [31:0] IP_A = 32'h0A00_0001;
  localparam logic [31:0] IP_B = 32'h0A00_0002;

  initial begin
    logic [31:0] ip;
    logic [4:0]  exp_t1;
    rst_n = 1'b0; hdr_valid = 1'b0; src_ip = '0; dst_port = '0; proto = '0;
    http_get = 1'b0; http_post = 1'b0; enable = 1'b1; threshold = 16'd3;
    #12;
    check_reset_vals("por");

    // Threshold 3: five GETs from one IP -> pass x3, drop x2
    do_reset();
    exp_t1 = 5'b11000;
    for (int i = 0; i < 5; i++)
      send(IP_A, 16'd80, 8'd6, 1'b1, 1'b0, exp_t1[i], $sformatf("t1_%0d", i));
    check_eq("t1_flood", flood_drop_count, 32'd2);
    check_eq("t1_used",  32'(entries_used), 32'd1);

    // Non-candidates with threshold 0 never drop and never allocate
    do_reset();
    threshold = 16'd0;
    for (int i = 0; i < 10; i++) begin
      send(IP_A, 16'd8080, 8'd6,  1'b1, 1'b0, 1'b0, "t2_port");
      send(IP_B, 16'd80,   8'd17, 1'b0, 1'b1, 1'b0, "t2_udp");
    end
    check_eq("t2_used",  32'(entries_used), 32'd0);
    check_eq("t2_flood", flood_drop_count, 32'd0);

    // Nine IPs into eight slots; victim pointer round-robins from slot 0
    do_reset();
    threshold = 16'd1;
    for (int i = 1; i <= 9; i++) begin
      ip = 32'h0A00_0100 + 32'(i);
      send(ip, 16'd80, 8'd6, 1'b0, 1'b1, 1'b0, $sformatf("t3_ip%0d", i));
      if (i == 8) check_eq("t3_used8", 32'(entries_used), 32'd8);
    end
    check_eq("t3_used9", 32'(entries_used), 32'd8);
    send(32'h0A00_0101, 16'd80, 8'd6, 1'b1, 1'b0, 1'b0, "t3_ip1_miss"); // evicts slot1 (ip2)
    send(32'h0A00_0103, 16'd80, 8'd6, 1'b1, 1'b0, 1'b1, "t3_ip3_hit");
    send(32'h0A00_0109, 16'd80, 8'd6, 1'b1, 1'b0, 1'b1, "t3_ip9_hit");
    send(32'h0A00_0101, 16'd80, 8'd6, 1'b1, 1'b0, 1'b1, "t3_ip1_hit");
    send(32'h0A00_0102, 16'd80, 8'd6, 1'b1, 1'b0, 1'b0, "t3_ip2_miss");
    check_eq("t3_flood", flood_drop_count, 32'd3);

    // Window of 64 cycles, threshold 1
    do_reset();
    send(IP_A, 16'd80, 8'd6, 1'b1, 1'b0, 1'b0, "t4_a1");      // accept edge 1
    send(IP_A, 16'd80, 8'd6, 1'b1, 1'b0, 1'b1, "t4_a2");      // edge 4, cnt 2
    wait_cyc(61);
    send(IP_A, 16'd80, 8'd6, 1'b1, 1'b0, 1'b0, "t4_updtick"); // UPD in tick cycle -> cnt 1
    check_eq("t4_used_a", 32'(entries_used), 32'd1);
    send(IP_A, 16'd80, 8'd6, 1'b1, 1'b0, 1'b1, "t4_a3");      // cnt 2 after restart
    send(IP_B, 16'd80, 8'd6, 1'b1, 1'b0, 1'b0, "t4_b1");
    check_eq("t4_used_b", 32'(entries_used), 32'd2);
    wait_cyc(126);
    send(IP_A, 16'd80, 8'd6, 1'b1, 1'b0, 1'b0, "t4_cmptick"); // CMP in tick cycle -> miss
    check_eq("t4_used_c", 32'(entries_used), 32'd1);
    send(IP_A, 16'd80, 8'd6, 1'b1, 1'b0, 1'b1, "t4_a4");
    send(IP_B, 16'd80, 8'd6, 1'b1, 1'b0, 1'b0, "t4_b2");      // B was cleared by tick

    // Disabled: no drops but table still counts
    do_reset();
    enable = 1'b0; threshold = 16'd0;
    for (int i = 0; i < 3; i++) send(IP_A, 16'd80, 8'd6, 1'b1, 1'b0, 1'b0, "t5_dis");
    check_eq("t5_flood0", flood_drop_count, 32'd0);
    check_eq("t5_used",   32'(entries_used), 32'd1);
    enable = 1'b1;
    send(IP_A, 16'd80, 8'd6, 1'b1, 1'b0, 1'b1, "t5_en");
    check_eq("t5_flood1", flood_drop_count, 32'd1);

    // Reset while a header is in CMP: verdict discarded
    do_reset();
    hdr_valid = 1'b1; src_ip = IP_A; dst_port = 16'd80; proto = 8'd6;
    http_get = 1'b1; http_post = 1'b0;
    @(posedge clk);
    @(negedge clk);
    hdr_valid = 1'b0;
    check_eq("t6_incmp_rdy", 32'(hdr_rdy), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6_rst");
    for (int i = 0; i < 4; i++) @(negedge clk);
    check_eq("t6_nopulse", 32'(vcount), 32'(exp_v));
    rst_n = 1'b1;
    check_reset_vals("t6_rel");
    send(IP_B, 16'd80, 8'd6, 1'b1, 1'b0, 1'b1, "t6_first"); // threshold 0, enabled
    check_eq("t6_used", 32'(entries_used), 32'd1);

    for (int i = 0; i < 3; i++) @(negedge clk);
    check_eq("pulse_count", 32'(vcount), 32'(exp_v));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/http_flood_detector.md
# http_flood_detector

Per-source HTTP GET/POST rate detector for the DDoS firewall datapath. It sits between the header extractor and the decision stage. For every parsed header it returns exactly one verdict: drop or pass. A packet is dropped when its source IP has sent more than a software-set number of HTTP GET/POST requests to the HTTP port within the current time window. Source IPs are tracked in a small fully-associative table that is cleared at the end of every window.

## Interface
Parameters:
- NUM_ENTRIES, 8: tracked source-IP slots; power of two, ≥2.
- CNT_WIDTH, 16: per-entry request counter width.
- WINDOW_CYCLES, 125000000: window length in clk cycles (1 s at 125 MHz); ≥8.
- HTTP_PORT, 80: destination port classified as HTTP.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- hdr_valid  in  1  header fields valid; accepted when hdr_valid && hdr_rdy.
- hdr_rdy  out  1  block can accept a header.
- src_ip  in  32  IPv4 source address.
- dst_port  in  16  TCP destination port.
- proto  in  8  IP protocol number.
- http_get  in  1  payload starts with "GET ".
- http_post  in  1  payload starts with "POST".
- enable  in  1  software enable; 0 forces verdict_drop=0.
- threshold  in  CNT_WIDTH  maximum requests per IP per window.
- verdict_valid  out  1  one-cycle pulse, one per accepted header.
- verdict_drop  out  1  1 = drop packet; qualified by verdict_valid.
- verdict_src_ip  out  32  src_ip of the judged header.
- flood_drop_count  out  32  saturating count of drop verdicts.
- entries_used  out  log2(NUM_ENTRIES)+1  number of valid table entries.

## Operation
- Candidate: proto==6 && dst_port==HTTP_PORT && (http_get || http_post). All other headers are non-candidates: they get verdict_drop=0 and do not touch the table.
- Table entry fields: valid, ip[31:0], cnt[CNT_WIDTH-1:0].
- FSM states: IDLE → CMP → UPD → IDLE.
  - IDLE: hdr_rdy=1. On accept, register the fields and the candidate flag, then go to CMP.
  - CMP: compare against all valid entries in parallel. Register hit and hit_idx. Register free_idx, the lowest-index invalid entry, plus a "full" flag.
  - UPD: target entry selection:
    - hit: hit_idx; new_cnt = cnt+1, saturating at 2^CNT_WIDTH-1.
    - miss, not full: free_idx; entry installed with new_cnt=1.
    - miss, full: victim pointer vptr; entry installed with new_cnt=1; vptr increments modulo NUM_ENTRIES.
  - UPD drop rule: drop = candidate && enable && (new_cnt > threshold). Register the verdict outputs. Go to IDLE.
- flood_drop_count increments by 1 on every drop verdict and saturates at 0xFFFFFFFF. It is never cleared by the window.
- Window timer: counts 0..WINDOW_CYCLES-1 and wraps. The wrap cycle is the tick. On tick, all valid bits and counters clear; vptr and flood_drop_count are kept.
- Tick in the same cycle as UPD: the clear applies first, then the current candidate is installed alone at its target index with new_cnt=1. The verdict is computed with new_cnt=1.
- Tick during CMP: the registered hit/free results are stale. UPD must treat the packet as a miss into an empty table: install at index 0 with new_cnt=1.
- threshold=0: every enabled candidate is dropped.
- Changes to threshold or enable take effect for the UPD cycle in which they are sampled.

## Timing
- Accept in cycle T. verdict_valid is high in cycle T+3 for exactly one cycle.
- hdr_rdy is low in T+1 through T+2 and high again at T+3. Maximum throughput is one header every 3 cycles.
- The table write becomes visible to the CMP of the next header. There is no same-IP forwarding hazard because requests are serialized.
- Reset (asserted asynchronously) forces:
  - FSM to IDLE; hdr_rdy=1.
  - verdict_valid=0, verdict_drop=0, verdict_src_ip=0.
  - flood_drop_count=0, entries_used=0.
  - all entries invalid, vptr=0, window timer=0.
- A header in flight when reset asserts is discarded and produces no verdict.
- On deassertion, the first accept is possible in the first clk edge after release.

## Test plan
- Threshold 3, enable=1, five HTTP GETs from 10.0.0.1 to port 80. Required: verdicts pass, pass, pass, drop, drop; flood_drop_count=2; entries_used=1.
- HTTP-like header to port 8080, and a UDP header to port 80, each sent 10 times with threshold 0. Required: all verdicts pass; entries_used=0.
- Nine distinct IPs, NUM_ENTRIES=8. Required: first eight fill slots 0–7; the ninth replaces slot 0 (vptr becomes 1); a repeat of IP #1 misses and gets new_cnt=1.
- WINDOW_CYCLES=64, threshold 1, three GETs from one IP straddling a tick. Required: counts restart after the tick. A GET whose UPD coincides with the tick passes with cnt=1.
- enable=0 with threshold 0, GETs sent. Required: verdict_drop=0 and flood_drop_count stays 0, but entries are still counted. After enable=1, the next GET drops.
- Assert reset during CMP. Required: no verdict_valid pulse. All outputs read their reset values. hdr_rdy=1 on the first edge after release.
